// File: rtl/adpll_tx_mod_seq.sv
// Packet-level TX modulation sequencer driving adpll_ctr.data_mod: lock wait, preamble, LSB-first payload.
// Optional payload whitening with a 7-bit LFSR is enabled by defining ADPLL_TX_WHITEN_EN.
`timescale 1ns/1ps
module adpll_tx_mod_seq #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PERIOD_W = 8,
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned PRE_BITS = 8,
    parameter logic [PRE_BITS-1:0] PRE_PAT = 8'hAA
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                channel_lock_i,
    input  logic                start_i,
    input  logic [PERIOD_W-1:0] sym_period_i,
    input  logic [LEN_W-1:0]    pkt_len_i,
    input  logic [6:0]          whiten_seed_i,
    input  logic [DATA_W-1:0]   din_i,
    input  logic                din_valid_i,
    output logic                din_ready_o,
    output logic                data_mod_o,
    output logic                sym_strobe_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                abort_o,
    output logic                underrun_o
);

    localparam int unsigned MAX_BITS = (PRE_BITS > DATA_W) ? PRE_BITS : DATA_W;
    localparam int unsigned IDX_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_LOCK, PREAMBLE, PAYLOAD} state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d, per_q, per_d;
    logic [LEN_W-1:0]    len_q, len_d, word_q, word_d;
    logic [IDX_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic data_mod_q, data_mod_d, sym_strobe_q, sym_strobe_d, din_ready_q, din_ready_d;
    logic busy_q, busy_d, done_q, done_d, abort_q, abort_d, underrun_q, underrun_d;
    logic term, last_bit, nxt_last, pay_sym, load_seed, wbit;

    assign term     = (cnt_q == per_q - PERIOD_W'(1));
    assign last_bit = (state_q == PREAMBLE) ? (bit_q == IDX_W'(PRE_BITS - 1))
                                            : (bit_q == IDX_W'(DATA_W - 1));

`ifdef ADPLL_TX_WHITEN_EN
    logic [6:0] lfsr_q;
    assign wbit = lfsr_q[6];
`else
    logic unused_whiten;
    assign unused_whiten = ^{whiten_seed_i, pay_sym, load_seed};
    assign wbit          = 1'b0;
`endif

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        per_d        = per_q;
        len_d        = len_q;
        word_d       = word_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        data_mod_d   = data_mod_q;
        sym_strobe_d = 1'b0;
        done_d       = 1'b0;
        abort_d      = 1'b0;
        underrun_d   = underrun_q;
        pay_sym      = 1'b0;
        load_seed    = 1'b0;
        case (state_q)
            IDLE: begin
                data_mod_d = 1'b0;
                if (start_i) begin
                    per_d      = (sym_period_i == '0) ? PERIOD_W'(1) : sym_period_i;
                    len_d      = pkt_len_i;
                    underrun_d = 1'b0;
                    load_seed  = 1'b1;
                    cnt_d      = '0;
                    bit_d      = '0;
                    word_d     = '0;
                    state_d    = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                data_mod_d = 1'b0;
                if (channel_lock_i) begin
                    state_d      = PREAMBLE;
                    cnt_d        = '0;
                    bit_d        = '0;
                    data_mod_d   = PRE_PAT[0];
                    sym_strobe_d = 1'b1;
                end
            end
            default: begin
                if (!channel_lock_i) begin
                    abort_d    = 1'b1;
                    data_mod_d = 1'b0;
                    state_d    = IDLE;
                end else if (!term) begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end else if (!last_bit) begin
                    cnt_d        = '0;
                    bit_d        = bit_q + IDX_W'(1);
                    sym_strobe_d = 1'b1;
                    if (state_q == PREAMBLE) begin
                        data_mod_d = PRE_PAT[bit_d];
                    end else begin
                        shreg_d    = shreg_q >> 1;
                        data_mod_d = shreg_q[1] ^ wbit;
                        pay_sym    = 1'b1;
                    end
                end else if (word_q == len_q) begin
                    done_d     = 1'b1;
                    data_mod_d = 1'b0;
                    state_d    = IDLE;
                end else if (!din_valid_i) begin
                    underrun_d = 1'b1;
                    abort_d    = 1'b1;
                    data_mod_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    // Word handshake: first bit of the new word starts next cycle
                    cnt_d        = '0;
                    bit_d        = '0;
                    word_d       = word_q + LEN_W'(1);
                    shreg_d      = din_i;
                    data_mod_d   = din_i[0] ^ wbit;
                    sym_strobe_d = 1'b1;
                    pay_sym      = 1'b1;
                    state_d      = PAYLOAD;
                end
            end
        endcase
        if (!en_i) begin
            state_d      = IDLE;
            cnt_d        = '0;
            bit_d        = '0;
            word_d       = '0;
            data_mod_d   = 1'b0;
            sym_strobe_d = 1'b0;
            done_d       = 1'b0;
            abort_d      = 1'b0;
            underrun_d   = underrun_q;
            pay_sym      = 1'b0;
            load_seed    = 1'b0;
        end
        // din_ready is raised for the coming cycle if it will be a fetch cycle
        nxt_last    = ((state_d == PREAMBLE) && (bit_d == IDX_W'(PRE_BITS - 1))) ||
                      ((state_d == PAYLOAD)  && (bit_d == IDX_W'(DATA_W - 1)));
        din_ready_d = nxt_last && (cnt_d == per_d - PERIOD_W'(1)) && (word_d < len_d);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            per_q        <= PERIOD_W'(1);
            len_q        <= '0;
            word_q       <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            data_mod_q   <= 1'b0;
            sym_strobe_q <= 1'b0;
            din_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef ADPLL_TX_WHITEN_EN
            lfsr_q       <= 7'h01;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            per_q        <= per_d;
            len_q        <= len_d;
            word_q       <= word_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            data_mod_q   <= data_mod_d;
            sym_strobe_q <= sym_strobe_d;
            din_ready_q  <= din_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
            underrun_q   <= underrun_d;
`ifdef ADPLL_TX_WHITEN_EN
            if (load_seed) begin
                lfsr_q <= (whiten_seed_i == 7'h00) ? 7'h01 : whiten_seed_i;
            end else if (pay_sym) begin
                lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[3]};
            end
`endif
        end
    end

    assign din_ready_o  = din_ready_q;
    assign data_mod_o   = data_mod_q;
    assign sym_strobe_o = sym_strobe_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign abort_o      = abort_q;
    assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_adpll_tx_mod_seq.sv
// Scoreboard bench for adpll_tx_mod_seq: expected symbols/end events queued at stimulus, checked by a monitor.
`timescale 1ns/1ps
module tb_adpll_tx_mod_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       channel_lock = 1'b0;
    logic       start = 1'b0;
    logic [7:0] sym_period = 8'd0;
    logic [7:0] pkt_len = 8'd0;
    logic [6:0] whiten_seed = 7'd0;
    logic [7:0] din;
    logic       din_valid;
    logic din_ready_o, data_mod_o, sym_strobe_o, busy_o, done_o, abort_o, underrun_o;

    adpll_tx_mod_seq dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .channel_lock_i(channel_lock), .start_i(start),
        .sym_period_i(sym_period), .pkt_len_i(pkt_len), .whiten_seed_i(whiten_seed),
        .din_i(din), .din_valid_i(din_valid), .din_ready_o(din_ready_o), .data_mod_o(data_mod_o),
        .sym_strobe_o(sym_strobe_o), .busy_o(busy_o), .done_o(done_o), .abort_o(abort_o),
        .underrun_o(underrun_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic b; int p; } sym_t;
    typedef struct { int kind; bit chk_len; int total; } end_t;  // kind 1 = done, 2 = abort

    sym_t       exp_q[$];
    end_t       end_q[$];
    logic [7:0] feed_q[$];
    int  checks = 0, errors = 0, strobes_seen = 0;
    int  cur_len = 0, cur_exp = 0, total = 0;
    bit  active = 1'b0, feed_flush = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bits(input logic [7:0] v, input int n, input int p);
        for (int i = 0; i < n; i++) exp_q.push_back('{v[i], p});
    endtask

    task automatic push_end(input int kind, input bit cl, input int tot);
        end_t e;
        e.kind = kind; e.chk_len = cl; e.total = tot;
        end_q.push_back(e);
    endtask

    task automatic start_pkt(input int p, input int len, input logic [6:0] seed);
        @(posedge clk); #1;
        sym_period = 8'(p); pkt_len = 8'(len); whiten_seed = seed; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int maxc);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!(done_o || abort_o) && n < maxc);
        chk(name, int'(done_o || abort_o), 1);
        #2;
    endtask

    task automatic wait_strobes(input string name, input int target, input int maxc);
        int n;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (strobes_seen < target && n < maxc);
        chk(name, int'(strobes_seen >= target), 1);
    endtask

    task automatic flush();
        exp_q.delete();
        feed_q.delete();
        feed_flush = 1'b1;
        repeat (2) @(posedge clk);
        #1 feed_flush = 1'b0;
    endtask

    // Payload source: holds a word valid until it is accepted
    initial begin
        bit hs;
        din = 8'd0;
        din_valid = 1'b0;
        forever begin
            @(negedge clk);
            hs = din_valid && din_ready_o;
            @(posedge clk); #1;
            if (feed_flush) begin
                din_valid = 1'b0;
            end else if (hs || !din_valid) begin
                if (feed_q.size() > 0) begin
                    din = feed_q.pop_front();
                    din_valid = 1'b1;
                end else begin
                    din_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: pops an expected symbol on each strobe and an expected end event on done/abort
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
            end else begin
                if (done_o || abort_o) begin
                    if (end_q.size() == 0) begin
                        chk("unexpected_end", 1, 0);
                    end else begin
                        end_t e;
                        e = end_q.pop_front();
                        chk("end_kind", done_o ? 1 : 2, e.kind);
                        chk("end_data_mod", int'(data_mod_o), 0);
                        chk("end_busy", int'(busy_o), 0);
                        if (e.chk_len) begin
                            chk("last_sym_len", cur_len, cur_exp);
                            chk("sym_left", exp_q.size(), 0);
                        end
                        if (e.total != 0) chk("pkt_cycles", total, e.total);
                    end
                    active = 1'b0;
                end
                if (sym_strobe_o) begin
                    if (active) chk("sym_len", cur_len, cur_exp);
                    else total = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_sym", 1, 0);
                        cur_exp = 0;
                    end else begin
                        sym_t s;
                        s = exp_q.pop_front();
                        chk("sym_bit", int'(data_mod_o), int'(s.b));
                        cur_exp = s.p;
                    end
                    cur_len = 0;
                    active = 1'b1;
                    strobes_seen++;
                end
                if (!busy_o) active = 1'b0;
                if (active) begin cur_len++; total++; end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] wexp;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data_mod", int'(data_mod_o), 0);
        chk("rst_din_ready", int'(din_ready_o), 0);
        chk("rst_strobe", int'(sym_strobe_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_abort", int'(abort_o), 0);
        chk("rst_underrun", int'(underrun_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b1; channel_lock = 1'b1;

        // Nominal: P=32, two words, done after 24 symbols of 32 cycles
        feed_q.push_back(8'h0F); feed_q.push_back(8'hA5);
        push_bits(8'hAA, 8, 32); push_bits(8'h0F, 8, 32); push_bits(8'hA5, 8, 32);
        push_end(1, 1'b1, 768);
        start_pkt(32, 2, 7'h00);
        wait_end("nominal_end", 2000);

        // Rate: sym_period 0 and 1 both give one bit per clock
        feed_q.push_back(8'h3C);
        push_bits(8'hAA, 8, 1); push_bits(8'h3C, 8, 1); push_end(1, 1'b1, 16);
        start_pkt(0, 1, 7'h00);
        wait_end("rate0_end", 200);
        feed_q.push_back(8'h3C);
        push_bits(8'hAA, 8, 1); push_bits(8'h3C, 8, 1); push_end(1, 1'b1, 16);
        start_pkt(1, 1, 7'h00);
        wait_end("rate1_end", 200);

        // Underrun: only one of three words supplied
        feed_q.push_back(8'h81);
        push_bits(8'hAA, 8, 4); push_bits(8'h81, 8, 4); push_end(2, 1'b1, 64);
        start_pkt(4, 3, 7'h00);
        wait_end("underrun_end", 500);
        chk("underrun_sticky", int'(underrun_o), 1);
        // Preamble-only packet; its start clears underrun
        push_bits(8'hAA, 8, 2); push_end(1, 1'b1, 16);
        start_pkt(2, 0, 7'h00);
        @(negedge clk);
        chk("underrun_cleared", int'(underrun_o), 0);
        wait_end("pre_only_end", 200);
        chk("pre_only_din_ready", int'(din_ready_o), 0);

        // Lock loss mid-word 1; a start during WAIT_LOCK is ignored
        channel_lock = 1'b0;
        feed_q.push_back(8'h5A); feed_q.push_back(8'hC3);
        push_bits(8'hAA, 8, 8); push_bits(8'h5A, 8, 8); push_end(2, 1'b0, 0);
        base = strobes_seen;
        start_pkt(8, 2, 7'h00);
        repeat (5) @(posedge clk);
        start_pkt(3, 1, 7'h00);
        chk("busy_wait_lock", int'(busy_o), 1);
        chk("wait_lock_data_mod", int'(data_mod_o), 0);
        channel_lock = 1'b1;
        wait_strobes("lock_strobes", base + 10, 300);
        channel_lock = 1'b0;
        @(negedge clk);
        chk("lock_abort", int'(abort_o), 1);
        chk("lock_busy", int'(busy_o), 0);
        #2 flush();
        channel_lock = 1'b1;

        // Whitening: seed 0 forced to 7'h01, zero payload exposes LFSR bits
`ifdef ADPLL_TX_WHITEN_EN
        wexp = 8'h40;
`else
        wexp = 8'h00;
`endif
        feed_q.push_back(8'h00);
        push_bits(8'hAA, 8, 1); push_bits(wexp, 8, 1); push_end(1, 1'b1, 16);
        start_pkt(1, 1, 7'h00);
        wait_end("whiten_end", 200);

        // Enable low mid-payload: IDLE next cycle, no done
        feed_q.push_back(8'h33);
        push_bits(8'hAA, 8, 2); push_bits(8'h33, 8, 2);
        base = strobes_seen;
        start_pkt(2, 1, 7'h00);
        wait_strobes("en_strobes", base + 11, 200);
        en = 1'b0;
        @(negedge clk);
        chk("en_busy", int'(busy_o), 0);
        chk("en_data_mod", int'(data_mod_o), 0);
        chk("en_done", int'(done_o), 0);
        #2 flush();
        en = 1'b1;
        repeat (20) @(negedge clk);
        chk("en_still_idle", int'(busy_o), 0);

        // Async reset mid-payload: outputs drop immediately
        feed_q.push_back(8'hF0);
        push_bits(8'hAA, 8, 4); push_bits(8'hF0, 8, 4);
        base = strobes_seen;
        start_pkt(4, 1, 7'h00);
        wait_strobes("rst_strobes", base + 10, 200);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data_mod", int'(data_mod_o), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_strobe", int'(sym_strobe_o), 0);
        chk("arst_din_ready", int'(din_ready_o), 0);
        flush();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_idle", int'(busy_o), 0);

        chk("sym_queue_drained", exp_q.size(), 0);
        chk("end_queue_drained", end_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
